oam_dma: RTL



---
 rtl/dendy_pkg.sv | 15 +
 rtl/oam_dma.sv | 108 ++++++++++
 2 files changed

// File: rtl/dendy_pkg.sv
// Shared types and bus addresses for the sprite DMA engine.
package dendy_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_t;

    localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
    localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA: a CPU write to TRIG_ADDR stalls the CPU and copies page {cpu_d,00..FF}
// into OAM_ADDR, one read tick and one write tick per byte.
//   state | meaning
//   IDLE  | CPU owns the bus, watching for the trigger write
//   HALT  | first stalled tick, decides whether alignment is needed
//   ALIGN | extra tick so READ ticks land on even parity
//   READ  | fetch byte {page,idx} into latch
//   WRITE | store latch to OAM_ADDR, advance or finish
module oam_dma
    import dendy_pkg::*;
#(
    parameter logic [15:0] TRIG_ADDR = ADDR_OAMDMA,
    parameter logic [15:0] OAM_ADDR  = ADDR_OAMDATA,
    parameter bit          ALIGN_EN  = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ce,
    output logic        cpu_ce,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_d,
    input  logic        cpu_r,
    input  logic        cpu_w,
    input  logic [7:0]  bus_i,
    output logic [15:0] bus_a,
    output logic [7:0]  bus_d,
    output logic        bus_r,
    output logic        bus_w,
    output logic        busy,
    output logic [7:0]  dma_idx
);

    dma_state_t state;
    logic [7:0] page;
    logic [7:0] idx;
    logic [7:0] latch;
    logic       parity;

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            page   <= 8'h00;
            idx    <= 8'h00;
            latch  <= 8'h00;
            parity <= 1'b0;
        end else if (ce) begin
            parity <= ~parity;
            case (state)
                IDLE: begin
                    if (cpu_w && (cpu_a == TRIG_ADDR)) begin
                        page  <= cpu_d;
                        idx   <= 8'h00;
                        state <= HALT;
                        busy  <= 1'b1;
                    end
                end
                // parity here is the HALT tick's; odd means the next tick is even
                HALT:  state <= (ALIGN_EN && !parity) ? ALIGN : READ;
                ALIGN: state <= READ;
                READ: begin
                    latch <= bus_i;
                    state <= WRITE;
                end
                WRITE: begin
                    if (idx == 8'hFF) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        idx   <= idx + 8'd1;
                        state <= READ;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus_a = cpu_a;
        bus_d = cpu_d;
        bus_r = cpu_r;
        bus_w = cpu_w;
        if (busy) begin
            bus_r = 1'b0;
            bus_w = 1'b0;
            case (state)
                READ: begin
                    bus_a = {page, idx};
                    bus_r = 1'b1;
                end
                WRITE: begin
                    bus_a = OAM_ADDR;
                    bus_d = latch;
                    bus_w = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign cpu_ce  = ce & ~busy;
    assign dma_idx = idx;

endmodule
